serial_attenuator: RTL
======================

# serial_attenuator

Bit-serial I2S attenuator placed directly upstream of the bit-serial delay stage. It applies an arithmetic right shift of 0..max_shift bits to each MSB-first two's-complement channel word as it streams through. It uses the same oversampled bclk/lrclk framing as the rest of the bit-serial chain, so its output feeds the delay stage's `in` without re-alignment. The shift amount is latched per word, and one extra code mutes the channel.

## Interface
Parameters:
- `w_word`, default 32: bits per channel word, MSB first.
- `max_shift`, default 8: largest supported shift; requires 1 ≤ max_shift ≤ w_word-1.

Ports:
- `clk`  in  1: system clock; bclk/lrclk/in are synchronous to it, and clk ≥ 4× bclk.
- `rst`  in  1: synchronous, active-high reset.
- `bclk`  in  1: I2S bit clock, sampled by `clk`.
- `lrclk`  in  1: I2S word select, sampled by `clk`.
- `shift`  in  $clog2(max_shift+2): requested shift; the value max_shift+1 (or greater) means mute.
- `in`  in  1: serial data; changes after bclk falls and is sampled on bclk rise.
- `out`  out  1: attenuated serial data, aligned slot-for-slot with `in`.

## Operation
- Edge detection: `bclk_prev` is registered every clk.
  - Rise = record event: bclk_prev=0, bclk=1.
  - Fall = play event: bclk_prev=1, bclk=0.
- Framing, evaluated on each play event, using `lrclk_prev` (updated on play events only):
  - If lrclk ≠ lrclk_prev, set `armed` = 1. This slot is the previous word's last I2S slot.
  - Else if `armed`, set `pos` = 0, `armed` = 0, and latch `shift_buf` ← `shift`. This is the MSB slot.
  - Else set `pos` ← pos+1, saturating at w_word (idle).
- Record event:
  - Always shift `in` into `hist`: `hist` = {hist[max_shift-2:0], in}, so hist[0] is the newest bit.
  - If pos==0, also capture `sign` ← in.
- Play event, computing `out_reg` for the new pos p (after the framing update):
  - p==0: out_reg = 0 (unused).
  - 1 ≤ p < shift_buf: out_reg = `sign`.
  - shift_buf ≤ p < w_word: out_reg = hist[shift_buf-1], which is input bit p-shift_buf.
  - p ≥ w_word: out_reg = 0.
- Output mux (combinational):
  - shift_buf == 0: out = in (bypass).
  - shift_buf > max_shift: out = 0 (mute).
  - pos == 0: out = in. The result MSB equals the input sign bit.
  - Otherwise out = out_reg.
- Result per word equals the arithmetic shift floor(x / 2^shift_buf), with the LSBs truncated. No rounding and no saturation are needed.
- A change of `shift` mid-word takes effect only at the next MSB slot of either channel.
- Left and right channels are processed identically. No per-channel state exists beyond the current word.

## Timing
- Reset (rst=1 at a clk edge) sets:
  - bclk_prev=0, lrclk_prev=0, armed=0;
  - pos=w_word, shift_buf=0, sign=0, out_reg=0, hist=0.
- After reset, out = in (bypass) until the first MSB slot latches a nonzero shift.
- Reset mid-word: the remainder of that word passes through unmodified. Attenuation resumes at the next word boundary after an lrclk change.
- Latency: zero bclk slots. `out` for slot p is valid within 1 clk after the falling bclk that opens slot p, and stable through the following rising bclk.
- A record event and a play event never occur on the same clk. No other simultaneous-event priority is required.
- Words shorter than the half-frame: slots with pos ≥ w_word output 0.
- Missing lrclk toggle: pos stays saturated and out_reg stays 0. Bypass still applies if shift_buf==0.
- The pos counter is $clog2(w_word+1) bits wide. The shift_buf comparisons are unsigned.

## Test plan
- w_word=32, shift=2, left word 0x80000004, right word 0x7FFFFFFC: required out words 0xE0000001 and 0x1FFFFFFF, slot-aligned with the input.
- shift=0, random stream over 4 frames: out is bit-identical to in, including slots before the first lrclk change.
- shift=max_shift+1 (9): out is 0 in every slot, including the MSB slot. Return to shift=3 with input 0x40000000: out is 0x08000000 from the next word.
- Change shift 1→4 in the middle of word 0x80000000: the current word outputs 0xC0000000, and the next word outputs 0xF8000000.
- Assert rst for 1 clk at slot 10 of a word with shift=2: the remainder of that word equals in, and the next word is attenuated correctly.
- w_word=24 with 32-slot half-frames, shift=1, input 0x800000: out MSBs are 0xC00000, and slots 24..31 are 0.

Source files
------------

// File: rtl/serial_attenuator_if.sv
// Bit-serial I2S stream bundle for the attenuator: framing clocks, shift request, data in/out.
interface serial_attenuator_if #(
  parameter int unsigned max_shift = 8
) ();
  localparam int unsigned ShiftW = $clog2(max_shift + 2);

  logic              bclk;
  logic              lrclk;
  logic [ShiftW-1:0] shift;
  logic              in;
  logic              out;

  // Stream source / consumer side.
  modport master (
    output bclk,
    output lrclk,
    output shift,
    output in,
    input  out
  );

  // Attenuator side.
  modport slave (
    input  bclk,
    input  lrclk,
    input  shift,
    input  in,
    output out
  );
endinterface

// File: rtl/serial_attenuator.sv
// Bit-serial arithmetic right shift (attenuation) of MSB-first two's-complement I2S words.
// Zero slot latency: the MSB passes straight through and later slots replay delayed bits.
module serial_attenuator #(
  parameter int unsigned w_word    = 32,
  parameter int unsigned max_shift = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_attenuator_if.slave bus
);
  localparam int unsigned ShiftW = $clog2(max_shift + 2);
  localparam int unsigned PosW   = $clog2(w_word + 1);

  localparam logic [PosW-1:0]   PosIdle  = PosW'(w_word);
  localparam logic [ShiftW-1:0] ShiftMax = ShiftW'(max_shift);

  logic                 bclk_prev_q, bclk_prev_d;
  logic                 lrclk_prev_q, lrclk_prev_d;
  logic                 armed_q, armed_d;
  logic [PosW-1:0]      pos_q, pos_d;
  logic [ShiftW-1:0]    shift_buf_q, shift_buf_d;
  logic                 sign_q, sign_d;
  logic                 out_reg_q, out_reg_d;
  logic [max_shift-1:0] hist_q, hist_d;
  logic [max_shift:0]   hist_ext;
  logic                 rec_ev, play_ev;
  logic                 hist_sel;

  // bclk edge detection: rise records a bit, fall opens a new output slot.
  always_comb begin
    bclk_prev_d = bus.bclk;
    rec_ev      = ~bclk_prev_q & bus.bclk;
    play_ev     = bclk_prev_q & ~bus.bclk;
  end

  // Word framing: an lrclk change arms, the following slot is the MSB and latches the shift.
  always_comb begin
    lrclk_prev_d = lrclk_prev_q;
    armed_d      = armed_q;
    pos_d        = pos_q;
    shift_buf_d  = shift_buf_q;
    if (play_ev) begin
      lrclk_prev_d = bus.lrclk;
      if (bus.lrclk != lrclk_prev_q) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        pos_d       = '0;
        armed_d     = 1'b0;
        shift_buf_d = bus.shift;
      end else if (pos_q != PosIdle) begin
        pos_d = pos_q + PosW'(1);
      end
    end
  end

  // Record side: delay line of recent input bits and the sign captured in the MSB slot.
  always_comb begin
    hist_ext = {hist_q, bus.in};
    hist_d   = rec_ev ? hist_ext[max_shift-1:0] : hist_q;
    sign_d   = (rec_ev && (pos_q == '0)) ? bus.in : sign_q;
  end

  // Play side: sign extension for the first shift_buf slots, then the bit delayed by shift_buf.
  always_comb begin
    hist_sel = 1'b0;
    for (int unsigned k = 0; k < max_shift; k++) begin
      if (shift_buf_d == ShiftW'(k + 1)) hist_sel = hist_q[k];
    end
    out_reg_d = out_reg_q;
    if (play_ev) begin
      if ((pos_d == '0) || (pos_d >= PosIdle)) begin
        out_reg_d = 1'b0;
      end else if (pos_d < PosW'(shift_buf_d)) begin
        out_reg_d = sign_q;
      end else begin
        out_reg_d = hist_sel;
      end
    end
  end

  // Output select: bypass, mute, MSB pass-through, or the replayed bit.
  always_comb begin
    if (shift_buf_q == '0) begin
      bus.out = bus.in;
    end else if (shift_buf_q > ShiftMax) begin
      bus.out = 1'b0;
    end else if (pos_q == '0) begin
      bus.out = bus.in;
    end else begin
      bus.out = out_reg_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_prev_q  <= 1'b0;
      lrclk_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      pos_q        <= PosIdle;
      shift_buf_q  <= '0;
      sign_q       <= 1'b0;
      out_reg_q    <= 1'b0;
      hist_q       <= '0;
    end else begin
      bclk_prev_q  <= bclk_prev_d;
      lrclk_prev_q <= lrclk_prev_d;
      armed_q      <= armed_d;
      pos_q        <= pos_d;
      shift_buf_q  <= shift_buf_d;
      sign_q       <= sign_d;
      out_reg_q    <= out_reg_d;
      hist_q       <= hist_d;
    end
  end
endmodule
